spi_result_tx: RTL
==================

Name: spi_result_tx

Overview:
Serial transmitter on the result side of the AES core: the counterpart of the existing SPI-style receivers that load plaintext and key.
- Captures a DATASIZE-bit word (encrypted or decrypted block) on a load pulse.
- Shifts the word out MSB-first on miso while the external chip-select cs is low, all synchronous to the core clock clk.
- Signals completion with a one-cycle done pulse.

Parameters:
DATASIZE, 128, width of the word shifted out, in bits (must be ≥ 2)
CNTW, $clog2(DATASIZE+8), bit-counter width

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
load  input  1  capture data_in; accepted only when ready=1
data_in  input  DATASIZE  word to transmit, e.g. the cipher output
cs  input  1  active-low select from the external reader; shifting advances only while cs=0
miso  output  1  serial data out, MSB first
ready  output  1  idle, can accept load
busy  output  1  word held or shifting (ARMED or SHIFT states)
done  output  1  one-cycle pulse after the last bit has been shifted

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, shift register=0, count=0, done=0.
- Resulting outputs: ready=1, busy=0, miso=0.
- Reset mid-frame drops the frame silently; no done pulse.

States:
- IDLE: ready=1, miso=0. load=1 → shreg<=data_in, count<=0, next ARMED. load is ignored in any other state (no queueing, shreg unchanged).
- ARMED: word held, miso=0 while cs=1. First rising edge with cs=0 → shift left once, count<=1, next SHIFT.
- SHIFT: each rising edge with cs=0 → shift left, count+1. cs=1 → pause: state, shreg and count hold. No abort, and resuming continues with the next bit.
- Last-bit edge (count=DATASIZE-1 with cs=0) → next IDLE, done<=1 for exactly one cycle.

miso:
- miso = shreg[DATASIZE-1] when cs=0 and state ∈ {ARMED, SHIFT}; otherwise 0 (combinational from the register and cs).
- Bit k of the frame (k=0 is the MSB) is visible during the k-th clk cycle in which cs is low.

Timing and boundary rules:
- Total frame: DATASIZE cs-low cycles. done is high in the cycle following the last bit's edge, with state already IDLE.
- load in the same cycle as done is accepted: ready=1 in that cycle.
- cs toggling every cycle is legal; only cs-low edges count.
- Zeros are shifted into the LSB. count never exceeds DATASIZE+8, with no wrap.
- busy = state ∈ {ARMED, SHIFT, CRC}; ready = state==IDLE.

Optional Feature:
Macro SPI_TX_CRC8_EN.
- Defined:
  - An 8-bit CRC (poly x^8+x^2+x+1 / 0x07, init 0x00, no reflection, no final XOR) is updated with each data bit as it is shifted out.
  - After the DATASIZE-th data bit the FSM enters state CRC and sends the 8 CRC bits MSB-first under the same cs-low/pause rules.
  - done pulses after the 8th CRC bit. Frame = DATASIZE+8 bits.
  - CRC register resets to 0 on rst and on accepted load.
- Undefined: no CRC logic or CRC state exists; frame = DATASIZE bits.

Test Plan:
1. Reset: rst=0 at random time mid-SHIFT → immediately miso=0, ready=1, busy=0, done=0; no done pulse follows.
2. Basic frame: load data_in=128'h00112233445566778899AABBCCDDEEFF, hold cs=0 → 128 sampled miso bits reassemble to the same value; done=1 exactly one cycle later, then ready=1.
3. Pause: same word, cs=1 for 5 cycles after bit 60 → miso=0 during pause; bits resume at bit 61 with no loss or duplication; done after 128 cs-low cycles.
4. Load ignored / back-to-back:
   - load 128'hA5…A5 during SHIFT of 128'h0 → transmitted word still all zeros.
   - load 128'hFFFF…FFFF in the done cycle → accepted; next frame is all ones.
5. ARMED hold: load 128'h8000…0001, keep cs=1 for 20 cycles → miso=0, busy=1. Drop cs → first bit 1, then 126 zeros, last bit 1.
6. With SPI_TX_CRC8_EN: data_in=128'h1 → 136-bit frame; last 8 bits = 8'h07 (00000111), done after bit 136.

Source files
------------

// File: rtl/spi_result_tx.sv
// Serial result transmitter: captures a DATASIZE-bit word and shifts it out MSB-first.
// Latency: the first bit is visible in the first cs-low cycle after load; done follows the last bit's edge.
// Backpressure: load is accepted only while ready; shifting advances only while cs is low.
//
// Ports:
//   clk      system clock, rising-edge state updates
//   rst      asynchronous active-low reset
//   load     capture data_in when ready=1
//   data_in  word to transmit
//   cs       active-low select from the external reader
//   miso     serial data out, MSB first (0 when not selected or idle)
//   ready    idle, can accept load
//   busy     word held or shifting
//   done     one-cycle pulse after the last bit of the frame
//
// Optional: define SPI_TX_CRC8_EN to append a CRC-8 (poly 0x07, init 0x00)
// over the data bits, making the frame DATASIZE+8 bits long.
module spi_result_tx #(
  parameter int DATASIZE = 128,
  parameter int CNTW     = $clog2(DATASIZE + 8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                cs,
  output logic                miso,
  output logic                ready,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
`ifdef SPI_TX_CRC8_EN
    , CRC = 2'd3
`endif
  } state_t;

  localparam logic [CNTW-1:0] LAST_DATA = CNTW'(DATASIZE - 1);
`ifdef SPI_TX_CRC8_EN
  localparam logic [CNTW-1:0] LAST_CRC  = CNTW'(DATASIZE + 7);
`endif

  state_t              state, state_nxt;
  logic [DATASIZE-1:0] shreg, shreg_nxt;
  logic [CNTW-1:0]     count, count_nxt;
  logic                done_nxt;

`ifdef SPI_TX_CRC8_EN
  logic [7:0] crc, crc_nxt, crc_step;

  // CRC advanced by the data bit currently leaving the shift register.
  always_comb begin
    crc_step = {crc[6:0], 1'b0} ^ ({8{crc[7] ^ shreg[DATASIZE-1]}} & 8'h07);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
      done  <= 1'b0;
`ifdef SPI_TX_CRC8_EN
      crc   <= 8'h00;
`endif
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      count <= count_nxt;
      done  <= done_nxt;
`ifdef SPI_TX_CRC8_EN
      crc   <= crc_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    count_nxt = count;
    done_nxt  = 1'b0;
`ifdef SPI_TX_CRC8_EN
    crc_nxt   = crc;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          shreg_nxt = data_in;
          count_nxt = '0;
          state_nxt = ARMED;
`ifdef SPI_TX_CRC8_EN
          crc_nxt   = 8'h00;
`endif
        end
      end
      ARMED: begin
        if (!cs) begin
          shreg_nxt = {shreg[DATASIZE-2:0], 1'b0};
          count_nxt = CNTW'(1);
          state_nxt = SHIFT;
`ifdef SPI_TX_CRC8_EN
          crc_nxt   = crc_step;
`endif
        end
      end
      SHIFT: begin
        if (!cs) begin
          shreg_nxt = {shreg[DATASIZE-2:0], 1'b0};
`ifdef SPI_TX_CRC8_EN
          crc_nxt   = crc_step;
`endif
          if (count == LAST_DATA) begin
`ifdef SPI_TX_CRC8_EN
            // Data exhausted: keep counting through the CRC trailer.
            count_nxt = count + CNTW'(1);
            state_nxt = CRC;
`else
            state_nxt = IDLE;
            done_nxt  = 1'b1;
`endif
          end else begin
            count_nxt = count + CNTW'(1);
          end
        end
      end
`ifdef SPI_TX_CRC8_EN
      CRC: begin
        if (!cs) begin
          crc_nxt = {crc[6:0], 1'b0};
          if (count == LAST_CRC) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            count_nxt = count + CNTW'(1);
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // miso is combinational so each bit appears in the same cycle cs goes low.
  always_comb begin
    miso = 1'b0;
    if (!cs) begin
      case (state)
        ARMED, SHIFT: miso = shreg[DATASIZE-1];
`ifdef SPI_TX_CRC8_EN
        CRC:          miso = crc[7];
`endif
        default:      miso = 1'b0;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

endmodule
